mux3_sel_arbiter: RTL and testbench
===================================

Name: mux3_sel_arbiter

Overview:
Round-robin arbiter that owns the 3-bit select of the downstream 3-to-1 one-bit mux. Sources a, b and c each request the shared output line. The arbiter grants one source at a time and drives the mux select code for it: a = 3'b000, b = 3'b010, c = 3'b100. A hold limit bounds how long any one source keeps the line.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation; range 1..255; 0 disables preemption.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  3  request per source: bit0 = a, bit1 = b, bit2 = c; level, held high for the whole transaction
gnt  output  3  one-hot grant, same bit order as req; all-zero when idle
s  output  3  mux select code: 3'b000 (a), 3'b010 (b), 3'b100 (c); 3'b001 when idle (park code, downstream mux holds last value)
busy  output  1  high while any grant is active
hold_cnt  output  8  cycles the current owner has held the grant, 1-based; 0 when idle

Behaviour:
- Reset is synchronous, active-high. At a clk edge with reset=1:
  - gnt=3'b000, s=3'b001, busy=0, hold_cnt=0.
  - Round-robin pointer last=2, so a has top priority after reset.
  - Reset overrides every other event, including mid-grant.
- All outputs are registered. There is no combinational path from req to any output.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - At each edge, if req!=0, grant the first requester searching from (last+1) mod 3 upward with wrap.
  - Next cycle: gnt = that one-hot bit, s = its code, busy=1, hold_cnt=1, state GRANT.
  - Latency from first req high to gnt is 1 cycle.
- GRANT, with owner o:
  - Release: req[o]=0 sampled at an edge. Set last=o. At the same edge, re-arbitrate over the sampled req from (o+1) mod 3.
    - If another request is pending, switch with no bubble; hold_cnt=1.
    - Otherwise go to IDLE: gnt=0, s=3'b001, hold_cnt=0.
  - Preempt: req[o]=1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
    - If another requester is pending, set last=o and grant the next one by round-robin; hold_cnt=1. The preempted source keeps req high and re-competes normally.
    - If none is pending, o keeps the grant and hold_cnt restarts at 1.
  - Otherwise: hold, and hold_cnt increments, saturating at 255 (relevant only when MAX_HOLD=0).
- gnt is always one-hot or zero. s is always exactly one of 000/010/100/001. The encoding is fixed: s = {gnt[2], gnt[1], 1'b0} when busy, else 3'b001.
- Simultaneous requests are resolved purely by the round-robin pointer, never by fixed priority, except immediately after reset.
- A req pulse shorter than one cycle that is not sampled at an edge is ignored. A 1-cycle req on the owner grants for exactly 1 cycle.
- Reset asserted mid-grant: the next cycle is idle regardless of req. Arbitration resumes one cycle after reset deasserts, with a first.

Test Plan:
- Reset, then req=3'b111 held -> cycle+1: gnt=001, s=000, busy=1. With MAX_HOLD=16: gnt=001 for 16 cycles, then 010 (s=010) for 16 cycles, then 100 (s=100), then back to 001.
- req=3'b010 for 3 cycles, then 0 -> gnt=010 for exactly 3 cycles starting 1 cycle after req rise. Then gnt=000, s=001, hold_cnt=0.
- Owner a releases while req=3'b110 pending -> next cycle gnt=010 with no idle cycle, hold_cnt=1. After b releases -> gnt=100.
- MAX_HOLD=4, only req[2]=1 for 10 cycles -> gnt=100 continuously; hold_cnt sequence 1,2,3,4,1,2,3,4,1,2.
- reset pulsed for 1 cycle during a c grant with req=3'b111 -> next cycle gnt=000, s=001. Following cycle gnt=001 (a first).
- MAX_HOLD=0, req=3'b011 held 300 cycles -> gnt stays 001 throughout; hold_cnt saturates at 255.

Source files
------------

// File: rtl/mux3_sel_arbiter.sv
// Round-robin arbiter driving the 3-bit select of a downstream 3:1 mux, with a hold limit.
// Latency: 1 cycle from sampled req to gnt/s; all outputs come from registers.
// Backpressure: none; an owner keeps the line until it drops req or is preempted at MAX_HOLD.
module mux3_sel_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [2:0] s,
  output logic       busy,
  output logic [7:0] hold_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit         PREEMPT  = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] owner_oh;
  logic [2:0] others;

  function automatic logic [1:0] next3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First set bit of r searching upward from index 'from' with wrap; lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] from);
    logic [1:0] pick;
    logic [2:0] sum;
    logic [1:0] idx;
    pick = from;
    for (int i = 2; i >= 0; i--) begin
      sum = {1'b0, from} + 3'(i);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign owner_oh = 3'b001 << owner_q;
  assign others   = req & ~owner_oh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          owner_d = rr_pick(req, next3(last_q));
          cnt_d   = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          last_d = owner_q;
          if (req != 3'b000) begin
            owner_d = rr_pick(req, next3(owner_q));
            cnt_d   = 8'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else if (PREEMPT && cnt_q == HOLD_LIM) begin
          // With no competitor the owner simply starts a fresh hold window.
          cnt_d = 8'd1;
          if (others != 3'b000) begin
            last_d  = owner_q;
            owner_d = rr_pick(others, next3(owner_q));
          end
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == GRANT);
  assign gnt      = busy ? owner_oh : 3'b000;
  assign s        = busy ? {gnt[2], gnt[1], 1'b0} : 3'b001;
  assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_mux3_sel_arbiter.sv
// Bench: three arbiters (MAX_HOLD 16, 4, 0) on shared inputs, checked each cycle against a
// queue-free behavioural model, plus literal checkpoints from the test plan.
module tb_mux3_sel_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [2:0] gnt_w [3];
  logic [2:0] s_w   [3];
  logic       busy_w[3];
  logic [7:0] hc_w  [3];

  int checks   = 0;
  int failures = 0;

  int maxh_m [3];
  int owner_m[3];
  int cnt_m  [3];
  int last_m [3];

  always #5 clk = ~clk;

  mux3_sel_arbiter #(.MAX_HOLD(16)) u_h16 (.clk(clk), .reset(reset), .req(req),
    .gnt(gnt_w[0]), .s(s_w[0]), .busy(busy_w[0]), .hold_cnt(hc_w[0]));
  mux3_sel_arbiter #(.MAX_HOLD(4))  u_h4  (.clk(clk), .reset(reset), .req(req),
    .gnt(gnt_w[1]), .s(s_w[1]), .busy(busy_w[1]), .hold_cnt(hc_w[1]));
  mux3_sel_arbiter #(.MAX_HOLD(0))  u_h0  (.clk(clk), .reset(reset), .req(req),
    .gnt(gnt_w[2]), .s(s_w[2]), .busy(busy_w[2]), .hold_cnt(hc_w[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int from);
    for (int i = 0; i < 3; i++)
      if (r[(from + i) % 3]) return (from + i) % 3;
    return -1;
  endfunction

  task automatic model_step(input int k, input logic [2:0] r, input logic rst);
    logic [2:0] oth;
    if (rst) begin
      owner_m[k] = -1; cnt_m[k] = 0; last_m[k] = 2;
    end else if (owner_m[k] < 0) begin
      if (r != 3'b000) begin
        owner_m[k] = pick(r, (last_m[k] + 1) % 3);
        cnt_m[k]   = 1;
      end
    end else if (!r[owner_m[k]]) begin
      last_m[k]  = owner_m[k];
      owner_m[k] = pick(r, (owner_m[k] + 1) % 3);
      cnt_m[k]   = (owner_m[k] < 0) ? 0 : 1;
    end else if (maxh_m[k] != 0 && cnt_m[k] == maxh_m[k]) begin
      oth = r;
      oth[owner_m[k]] = 1'b0;
      cnt_m[k] = 1;
      if (oth != 3'b000) begin
        last_m[k]  = owner_m[k];
        owner_m[k] = pick(oth, (owner_m[k] + 1) % 3);
      end
    end else begin
      cnt_m[k] = (cnt_m[k] >= 255) ? 255 : cnt_m[k] + 1;
    end
  endtask

  task automatic compare_all();
    logic [2:0] eg, es;
    for (int k = 0; k < 3; k++) begin
      eg = (owner_m[k] < 0) ? 3'b000 : (3'b001 << owner_m[k]);
      es = (owner_m[k] < 0) ? 3'b001 : {eg[2], eg[1], 1'b0};
      chk($sformatf("model%0d_gnt", k),  int'(gnt_w[k]),  int'(eg));
      chk($sformatf("model%0d_s", k),    int'(s_w[k]),    int'(es));
      chk($sformatf("model%0d_busy", k), int'(busy_w[k]), (owner_m[k] < 0) ? 0 : 1);
      chk($sformatf("model%0d_hold", k), int'(hc_w[k]),   cnt_m[k]);
    end
  endtask

  // Apply inputs mid-cycle, let one rising edge pass, then compare at the falling edge.
  task automatic cyc(input logic [2:0] r, input logic rst);
    req = r;
    reset = rst;
    for (int k = 0; k < 3; k++) model_step(k, r, rst);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int exp4[10];
    logic [2:0] rr;
    exp4 = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
    maxh_m = '{16, 4, 0};
    for (int k = 0; k < 3; k++) begin
      owner_m[k] = -1; cnt_m[k] = 0; last_m[k] = 2;
    end
    req = 3'b000;
    reset = 1'b1;

    // Reset state and full three-way rotation with MAX_HOLD=16
    cyc(3'b000, 1'b1);
    chk("rst_gnt", int'(gnt_w[0]), 0);
    chk("rst_s", int'(s_w[0]), 1);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_hold", int'(hc_w[0]), 0);
    for (int n = 1; n <= 49; n++) begin
      cyc(3'b111, 1'b0);
      if (n == 1) begin
        chk("rot_first_gnt", int'(gnt_w[0]), 1);
        chk("rot_first_s", int'(s_w[0]), 0);
        chk("rot_first_busy", int'(busy_w[0]), 1);
      end
      if (n == 16) chk("rot_a_last_hold", int'(hc_w[0]), 16);
      if (n == 17) chk("rot_b_gnt", int'(gnt_w[0]), 2);
      if (n == 17) chk("rot_b_s", int'(s_w[0]), 2);
      if (n == 33) chk("rot_c_gnt", int'(gnt_w[0]), 4);
      if (n == 33) chk("rot_c_s", int'(s_w[0]), 4);
      if (n == 49) chk("rot_wrap_gnt", int'(gnt_w[0]), 1);
    end

    // Three-cycle request from b, then idle
    cyc(3'b000, 1'b1);
    for (int n = 1; n <= 3; n++) begin
      cyc(3'b010, 1'b0);
      chk("b3_gnt", int'(gnt_w[0]), 2);
    end
    cyc(3'b000, 1'b0);
    chk("b3_idle_gnt", int'(gnt_w[0]), 0);
    chk("b3_idle_s", int'(s_w[0]), 1);
    chk("b3_idle_hold", int'(hc_w[0]), 0);

    // Release with pending requests switches without a bubble
    cyc(3'b000, 1'b1);
    cyc(3'b001, 1'b0);
    chk("sw_a_gnt", int'(gnt_w[0]), 1);
    cyc(3'b110, 1'b0);
    chk("sw_b_gnt", int'(gnt_w[0]), 2);
    chk("sw_b_hold", int'(hc_w[0]), 1);
    cyc(3'b100, 1'b0);
    chk("sw_c_gnt", int'(gnt_w[0]), 4);

    // Lone requester with MAX_HOLD=4 keeps the line, count wraps
    cyc(3'b000, 1'b1);
    for (int n = 0; n < 10; n++) begin
      cyc(3'b100, 1'b0);
      chk("h4_gnt", int'(gnt_w[1]), 4);
      chk($sformatf("h4_hold%0d", n), int'(hc_w[1]), exp4[n]);
    end

    // Reset during a c grant
    cyc(3'b000, 1'b1);
    cyc(3'b100, 1'b0);
    chk("rmid_c_gnt", int'(gnt_w[0]), 4);
    cyc(3'b111, 1'b1);
    chk("rmid_gnt", int'(gnt_w[0]), 0);
    chk("rmid_s", int'(s_w[0]), 1);
    cyc(3'b111, 1'b0);
    chk("rmid_a_first", int'(gnt_w[0]), 1);

    // MAX_HOLD=0: no preemption, count saturates
    cyc(3'b000, 1'b1);
    for (int n = 1; n <= 300; n++) begin
      cyc(3'b011, 1'b0);
      chk("h0_gnt", int'(gnt_w[2]), 1);
    end
    chk("h0_sat", int'(hc_w[2]), 255);

    // Randomized level requests with occasional resets
    rr = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
      cyc(rr, ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
